// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit
// IF stage: holds the PC, fetches instructions over a req/ack memory
// handshake and feeds the IF/ID register through a one-entry output buffer.
// Honours stalls and branch/jump redirects (redirect has highest priority).
// Optional feature macro: FETCH_PERF_CNT_EN adds FetchCount_40/StallCount_40.
// Revision: 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk_40,
  input  logic        Rst_n_40,
  input  logic        Stall_40,
  input  logic        Redirect_40,
  input  logic [31:0] RedirectPC_40,
  output logic        ImemReq_40,
  output logic [31:0] ImemAddr_40,
  input  logic        ImemAck_40,
  input  logic [31:0] ImemData_40,
  output logic [31:0] instruction_out_40,
  output logic [31:0] PCNow_out_40,
  output logic [31:0] PCNext4_out_40,
  output logic        Write_40,
  output logic        Flush_40
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount_40,
  output logic [31:0] StallCount_40
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] req_addr;     // address of the request currently on the bus
  logic        pending;      // FETCH request issued, not yet acknowledged
  logic        out_valid;
  logic [31:0] instr_q;
  logic [31:0] pc_now_q;
  logic [31:0] pc_next4_q;
  logic        flush_q;
  logic        write_en;
  logic        can_req;
  logic        req;
  logic [31:0] addr;
  logic        accept;

  assign pc_plus4 = pc + 32'd4;   // wraps mod 2^32 naturally
  assign write_en = out_valid & ~Stall_40;
  // A new fetch may start only if the buffer will have room at the next edge
  assign can_req  = ~out_valid | write_en;
  // Ack data is taken only in FETCH and only when no redirect overrides it
  assign accept   = (state == ST_FETCH) & req & ImemAck_40 & ~Redirect_40;

  // Next-state and memory request decode
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = pc;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        // Once issued, a request is held until acknowledged, stall or not
        req = pending | can_req;
      end
      ST_DROP: begin
        // Finish the stale request on its original address, then discard it
        req  = 1'b1;
        addr = req_addr;
        if (ImemAck_40) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (Redirect_40) begin
      state_nxt = (req & ~ImemAck_40) ? ST_DROP : ST_FETCH;
    end
  end

  // State register
  always_ff @(posedge Clk_40 or negedge Rst_n_40) begin
    if (!Rst_n_40) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // PC, outstanding-request tracking and stale-address capture
  always_ff @(posedge Clk_40 or negedge Rst_n_40) begin
    if (!Rst_n_40) begin
      pc       <= RESET_PC;
      pending  <= 1'b0;
      req_addr <= 32'h0;
    end else begin
      if (Redirect_40)  pc <= RedirectPC_40 & ~32'h3;
      else if (accept)  pc <= pc_plus4;

      if (Redirect_40 || state != ST_FETCH) pending <= 1'b0;
      else                                  pending <= req & ~ImemAck_40;

      if (state == ST_FETCH && req) req_addr <= pc;
    end
  end

  // One-entry output buffer towards IF/ID
  always_ff @(posedge Clk_40 or negedge Rst_n_40) begin
    if (!Rst_n_40) begin
      out_valid  <= 1'b0;
      instr_q    <= 32'h0;
      pc_now_q   <= 32'h0;
      pc_next4_q <= 32'h0;
    end else begin
      if (Redirect_40)   out_valid <= 1'b0;
      else if (accept)   out_valid <= 1'b1;
      else if (write_en) out_valid <= 1'b0;

      if (accept) begin
        instr_q    <= ImemData_40;
        pc_now_q   <= pc;
        pc_next4_q <= pc_plus4;
      end
    end
  end

  // Single-cycle flush pulse following every redirect
  always_ff @(posedge Clk_40 or negedge Rst_n_40) begin
    if (!Rst_n_40) flush_q <= 1'b0;
    else           flush_q <= Redirect_40;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // Free-running performance counters; redirects do not clear them
  always_ff @(posedge Clk_40 or negedge Rst_n_40) begin
    if (!Rst_n_40) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (write_en)              fetch_cnt <= fetch_cnt + 32'd1;
      if (out_valid && Stall_40) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign FetchCount_40 = fetch_cnt;
  assign StallCount_40 = stall_cnt;
`endif

  assign ImemReq_40         = req;
  assign ImemAddr_40        = addr;
  assign instruction_out_40 = instr_q;
  assign PCNow_out_40       = pc_now_q;
  assign PCNext4_out_40     = pc_next4_q;
  assign Write_40           = write_en;
  assign Flush_40           = flush_q;

endmodule
`default_nettype wire
